// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-client memory arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUS_I = 2'd1,
        ARB_BUS_D = 2'd2,
        ARB_RESP  = 2'd3
    } arbState_t;

    // Owner codes reported on arb_owner
    localparam logic [1:0] OWNER_NONE  = 2'd0;
    localparam logic [1:0] OWNER_FETCH = 2'd1;
    localparam logic [1:0] OWNER_DATA  = 2'd2;

    localparam logic [3:0] BE_ALL = 4'hF;

    // Saturating increment of the data-streak counter
    function automatic logic [3:0] nextStreak(input logic [3:0] cur, input logic [3:0] limit);
        return (cur >= limit) ? limit : cur + 4'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-client arbiter sharing one single-ported memory between instruction
// fetch and load/store. Data accesses win, but after MAX_D_STREAK
// consecutive data grants with a fetch waiting, the fetch is served.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_req,
    input  logic [31:0] icache_addr,
    output logic [31:0] icache_data,
    output logic        icache_valid,
    input  logic        dcache_rreq,
    input  logic        dcache_wreq,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_wdata,
    input  logic [3:0]  dcache_byte_enable,
    output logic [31:0] dcache_rdata,
    output logic        dcache_rvalid,
    output logic        dcache_wvalid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [1:0]  arb_owner
);

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

    arbState_t   r_state;
    arbState_t   w_nextState;
    logic [3:0]  r_dStreak;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic [1:0]  r_owner;

    logic        w_dataReq;
    logic        w_fetchForced;
    logic        w_grantData;
    logic        w_grantFetch;
    logic        w_onBus;

    // Arbitration: data first unless the streak limit is hit with a fetch waiting
    always_comb begin
        w_dataReq     = dcache_wreq | dcache_rreq;
        w_fetchForced = (r_dStreak == STREAK_LIMIT) && icache_req;
        w_grantData   = (r_state == ARB_IDLE) && w_dataReq && !w_fetchForced;
        w_grantFetch  = (r_state == ARB_IDLE) && icache_req && !w_grantData;
        w_onBus       = (r_state == ARB_BUS_I) || (r_state == ARB_BUS_D);
    end

    // State register; reset abandons any in-flight access immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; requests are only looked at in IDLE
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_grantData) begin
                    w_nextState = ARB_BUS_D;
                end else if (w_grantFetch) begin
                    w_nextState = ARB_BUS_I;
                end
            end
            ARB_BUS_I, ARB_BUS_D: begin
                if (mem_ack) begin
                    w_nextState = ARB_RESP;
                end
            end
            ARB_RESP: begin
                w_nextState = ARB_IDLE;
            end
            default: begin
                w_nextState = ARB_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registers, so no input reaches an output combinationally
    always_comb begin
        mem_req       = w_onBus;
        mem_we        = r_we;
        mem_addr      = r_addr;
        mem_wdata     = r_wdata;
        mem_be        = r_be;
        icache_data   = r_rdata;
        dcache_rdata  = r_rdata;
        icache_valid  = (r_state == ARB_RESP) && (r_owner == OWNER_FETCH);
        dcache_rvalid = (r_state == ARB_RESP) && (r_owner == OWNER_DATA) && !r_we;
        dcache_wvalid = (r_state == ARB_RESP) && (r_owner == OWNER_DATA) && r_we;
        arb_owner     = (r_state == ARB_IDLE) ? OWNER_NONE : r_owner;
    end

    // Latch the winner's request on a grant and capture read data on ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_be    <= BE_ALL;
            r_we    <= 1'b0;
            r_owner <= OWNER_NONE;
        end else begin
            if (w_grantData) begin
                r_addr  <= dcache_addr;
                r_we    <= dcache_wreq;
                r_wdata <= dcache_wdata;
                r_be    <= dcache_wreq ? dcache_byte_enable : BE_ALL;
                r_owner <= OWNER_DATA;
            end else if (w_grantFetch) begin
                r_addr  <= icache_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
                r_be    <= BE_ALL;
                r_owner <= OWNER_FETCH;
            end
            if (w_onBus && mem_ack) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // Count data grants that overtook a waiting fetch; any other grant clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dStreak <= '0;
        end else if (w_grantData) begin
            r_dStreak <= icache_req ? nextStreak(r_dStreak, STREAK_LIMIT) : 4'd0;
        end else if (w_grantFetch) begin
            r_dStreak <= 4'd0;
        end
    end

endmodule
